// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: tag width, source encodings
// and the default per-source FIFO depth.
package cdb_arbiter_pkg;
  localparam int CDB_ROB_W      = 4;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;
endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-source result FIFO: power-of-two depth, wrapping pointers, flush clears
// occupancy. The caller never pushes into a full FIFO without a same-cycle pop.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W     = 36,
  parameter int DEPTH = CDB_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [PW:0]   count,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_in) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: ALU and LSB results are queued
// per source and one winner per cycle is registered onto the broadcast outputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W = CDB_ROB_W,
  parameter int DEPTH = CDB_FIFO_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_value,
  input  logic             alu_has_new_pc,
  input  logic [31:0]      alu_new_pc,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  output logic             alu_full,
  output logic             lsb_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_value,
  output logic             cdb_src,
  output logic             cdb_has_new_pc,
  output logic [31:0]      cdb_new_pc,
  output logic             ovf
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = ROB_W + 65;
  localparam int LW = ROB_W + 32;

  logic [AW-1:0] alu_in_ent, alu_dout, alu_head;
  logic [LW-1:0] lsb_in_ent, lsb_dout, lsb_head;
  logic [CW-1:0] alu_count, lsb_count;
  logic alu_empty, lsb_empty;
  logic act, flush, alu_hv, lsb_hv, contended, win_lsb, alu_win, lsb_win;
  logic alu_pop, lsb_pop, alu_push_req, lsb_push_req;
  logic alu_drop, lsb_drop, alu_push, lsb_push;

  logic             cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]      cdb_value_q, cdb_value_d;
  logic             cdb_src_q, cdb_src_d;
  logic             cdb_has_new_pc_q, cdb_has_new_pc_d;
  logic [31:0]      cdb_new_pc_q, cdb_new_pc_d;
  logic             rr_q, rr_d;
  logic             ovf_q, ovf_d;

  assign alu_in_ent = {alu_rob_id, alu_value, alu_has_new_pc, alu_new_pc};
  assign lsb_in_ent = {lsb_rob_id, lsb_value};

  always_comb begin
    act       = rdy_in && !rob_clear;
    flush     = rdy_in && rob_clear;
    alu_head  = alu_empty ? alu_in_ent : alu_dout;
    lsb_head  = lsb_empty ? lsb_in_ent : lsb_dout;
    alu_hv    = !alu_empty || alu_valid;
    lsb_hv    = !lsb_empty || lsb_valid;
    contended = alu_hv && lsb_hv;
    win_lsb   = contended ? (rr_q == SRC_LSB) : lsb_hv;
    alu_win   = act && alu_hv && !win_lsb;
    lsb_win   = act && lsb_hv && win_lsb;
    alu_pop   = alu_win && !alu_empty;
    lsb_pop   = lsb_win && !lsb_empty;
    // An input that wins while its FIFO is empty bypasses straight to the bus.
    alu_push_req = act && alu_valid && !(alu_win && alu_empty);
    lsb_push_req = act && lsb_valid && !(lsb_win && lsb_empty);
    alu_drop  = alu_push_req && (alu_count == CW'(DEPTH)) && !alu_pop;
    lsb_drop  = lsb_push_req && (lsb_count == CW'(DEPTH)) && !lsb_pop;
    alu_push  = alu_push_req && !alu_drop;
    lsb_push  = lsb_push_req && !lsb_drop;
  end

  always_comb begin
    cdb_valid_d      = cdb_valid_q;
    cdb_rob_id_d     = cdb_rob_id_q;
    cdb_value_d      = cdb_value_q;
    cdb_src_d        = cdb_src_q;
    cdb_has_new_pc_d = cdb_has_new_pc_q;
    cdb_new_pc_d     = cdb_new_pc_q;
    rr_d             = rr_q;
    ovf_d            = ovf_q;
    if (flush) begin
      cdb_valid_d      = 1'b0;
      cdb_has_new_pc_d = 1'b0;
    end else if (act) begin
      if (contended) rr_d = ~rr_q;
      if (alu_drop || lsb_drop) ovf_d = 1'b1;
      if (alu_win) begin
        cdb_valid_d      = 1'b1;
        cdb_src_d        = SRC_ALU;
        {cdb_rob_id_d, cdb_value_d, cdb_has_new_pc_d, cdb_new_pc_d} = alu_head;
      end else if (lsb_win) begin
        cdb_valid_d      = 1'b1;
        cdb_src_d        = SRC_LSB;
        {cdb_rob_id_d, cdb_value_d} = lsb_head;
        cdb_has_new_pc_d = 1'b0;
        cdb_new_pc_d     = '0;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_q      <= 1'b0;
      cdb_rob_id_q     <= '0;
      cdb_value_q      <= '0;
      cdb_src_q        <= SRC_ALU;
      cdb_has_new_pc_q <= 1'b0;
      cdb_new_pc_q     <= '0;
      rr_q             <= SRC_ALU;
      ovf_q            <= 1'b0;
    end else begin
      cdb_valid_q      <= cdb_valid_d;
      cdb_rob_id_q     <= cdb_rob_id_d;
      cdb_value_q      <= cdb_value_d;
      cdb_src_q        <= cdb_src_d;
      cdb_has_new_pc_q <= cdb_has_new_pc_d;
      cdb_new_pc_q     <= cdb_new_pc_d;
      rr_q             <= rr_d;
      ovf_q            <= ovf_d;
    end
  end

  cdb_fifo #(.W(AW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .push(alu_push), .pop(alu_pop), .flush(flush),
    .din(alu_in_ent), .dout(alu_dout), .count(alu_count), .empty(alu_empty)
  );

  cdb_fifo #(.W(LW), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .push(lsb_push), .pop(lsb_pop), .flush(flush),
    .din(lsb_in_ent), .dout(lsb_dout), .count(lsb_count), .empty(lsb_empty)
  );

  // One in-flight issue is always absorbed, so full asserts one slot early.
  assign alu_full       = (alu_count >= CW'(DEPTH - 1));
  assign lsb_full       = (lsb_count >= CW'(DEPTH - 1));
  assign cdb_valid      = cdb_valid_q;
  assign cdb_rob_id     = cdb_rob_id_q;
  assign cdb_value      = cdb_value_q;
  assign cdb_src        = cdb_src_q;
  assign cdb_has_new_pc = cdb_has_new_pc_q;
  assign cdb_new_pc     = cdb_new_pc_q;
  assign ovf            = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int ROB_W = 4;
  localparam int DEPTH = 4;
  localparam int AW    = ROB_W + 65;
  localparam int LW    = ROB_W + 32;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, rob_clear;
  logic alu_valid, alu_has_new_pc, lsb_valid;
  logic [ROB_W-1:0] alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, alu_new_pc, lsb_value;
  logic alu_full, lsb_full, cdb_valid, cdb_src, cdb_has_new_pc, ovf;
  logic [ROB_W-1:0] cdb_rob_id;
  logic [31:0] cdb_value, cdb_new_pc;

  int total = 0;
  int bad   = 0;

  // Reference model: pending results per source plus the visible bus state.
  logic [AW-1:0] aq[$];
  logic [LW-1:0] lq[$];
  logic m_rr, m_ovf, m_valid, m_src, m_hnp;
  logic [ROB_W-1:0] m_id;
  logic [31:0] m_val, m_npc;
  logic [ROB_W-1:0] got_a[$], got_l[$];

  cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value),
    .alu_has_new_pc(alu_has_new_pc), .alu_new_pc(alu_new_pc),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .alu_full(alu_full), .lsb_full(lsb_full), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src),
    .cdb_has_new_pc(cdb_has_new_pc), .cdb_new_pc(cdb_new_pc), .ovf(ovf)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_rr = 0; m_ovf = 0; m_valid = 0; m_src = 0; m_hnp = 0;
    m_id = '0; m_val = '0; m_npc = '0;
  endtask

  task automatic model_edge();
    logic ah, lh, pick_lsb, aw, lw;
    logic [AW-1:0] ae;
    logic [LW-1:0] le;
    if (!rdy_in) return;
    if (rob_clear) begin
      aq.delete(); lq.delete();
      m_valid = 0; m_hnp = 0;
      return;
    end
    ah = (aq.size() > 0) || alu_valid;
    lh = (lq.size() > 0) || lsb_valid;
    if (ah && lh) begin
      pick_lsb = m_rr;
      m_rr = !m_rr;
    end else pick_lsb = lh;
    aw = (ah || lh) && !pick_lsb;
    lw = (ah || lh) && pick_lsb;
    if (alu_valid) begin
      if (aq.size() == DEPTH && !aw) m_ovf = 1;
      else aq.push_back({alu_rob_id, alu_value, alu_has_new_pc, alu_new_pc});
    end
    if (lsb_valid) begin
      if (lq.size() == DEPTH && !lw) m_ovf = 1;
      else lq.push_back({lsb_rob_id, lsb_value});
    end
    if (aw) begin
      ae = aq.pop_front();
      m_valid = 1; m_src = 0;
      m_id = ae[AW-1:65]; m_val = ae[64:33]; m_hnp = ae[32]; m_npc = ae[31:0];
    end else if (lw) begin
      le = lq.pop_front();
      m_valid = 1; m_src = 1;
      m_id = le[LW-1:32]; m_val = le[31:0]; m_hnp = 0; m_npc = '0;
    end else m_valid = 0;
  endtask

  task automatic check_all();
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_rob_id", cdb_rob_id, m_id);
    check("cdb_value", cdb_value, m_val);
    check("cdb_src", cdb_src, m_src);
    check("cdb_has_new_pc", cdb_has_new_pc, m_hnp);
    check("cdb_new_pc", cdb_new_pc, m_npc);
    check("alu_full", alu_full, aq.size() >= DEPTH - 1);
    check("lsb_full", lsb_full, lq.size() >= DEPTH - 1);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
    if (cdb_valid && rdy_in) begin
      if (cdb_src) got_l.push_back(cdb_rob_id);
      else got_a.push_back(cdb_rob_id);
    end
  endtask

  task automatic idle();
    rdy_in = 1; rob_clear = 0;
    alu_valid = 0; alu_rob_id = '0; alu_value = '0; alu_has_new_pc = 0; alu_new_pc = '0;
    lsb_valid = 0; lsb_rob_id = '0; lsb_value = '0;
  endtask

  task automatic drive_alu(input int id, input logic [31:0] v, input logic h, input logic [31:0] pc);
    alu_valid = 1; alu_rob_id = ROB_W'(id); alu_value = v; alu_has_new_pc = h; alu_new_pc = pc;
  endtask

  task automatic drive_lsb(input int id, input logic [31:0] v);
    lsb_valid = 1; lsb_rob_id = ROB_W'(id); lsb_value = v;
  endtask

  task automatic randomize_inputs();
    alu_valid = 1'($urandom_range(0, 1)); alu_rob_id = ROB_W'($urandom);
    alu_value = $urandom; alu_has_new_pc = 1'($urandom_range(0, 1)); alu_new_pc = $urandom;
    lsb_valid = 1'($urandom_range(0, 1)); lsb_rob_id = ROB_W'($urandom); lsb_value = $urandom;
  endtask

  initial begin
    idle();
    rst_in = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1;

    // ALU result alone: one cycle latency, then bus idles.
    drive_alu(3, 32'h11, 0, 0);
    cycle();
    check("alu_only_id", cdb_rob_id, 3);
    check("alu_only_val", cdb_value, 32'h11);
    check("alu_only_src", cdb_src, 0);
    idle();
    cycle();
    check("alu_only_drop", cdb_valid, 0);

    // Contention twice: round-robin flips the winner order.
    for (int rep = 0; rep < 2; rep++) begin
      drive_alu(1, 32'hA, 0, 0);
      drive_lsb(2, 32'hB);
      cycle();
      check("cont_first_src", cdb_src, rep == 0 ? 1'b0 : 1'b1);
      idle();
      cycle();
      check("cont_second_src", cdb_src, rep == 0 ? 1'b1 : 1'b0);
      cycle();
    end

    // Both sources streaming: every tag appears once, in per-source order.
    got_a.delete(); got_l.delete();
    for (int i = 0; i < 4; i++) begin
      drive_alu(8 + i, 32'h100 + i, 0, 0);
      drive_lsb(4 + i, 32'h200 + i);
      cycle();
    end
    idle();
    repeat (6) cycle();
    check("bp_alu_cnt", got_a.size(), 4);
    check("bp_lsb_cnt", got_l.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_a.size()) check("bp_alu_order", got_a[i], 8 + i);
      if (i < got_l.size()) check("bp_lsb_order", got_l[i], 4 + i);
    end
    check("bp_ovf", ovf, 0);

    // Flush with results queued and a new ALU input in the same cycle.
    for (int i = 0; i < 4; i++) begin
      drive_alu(i, 32'h300 + i, 1, 32'h40 + i);
      drive_lsb(8 + i, 32'h400 + i);
      cycle();
    end
    idle();
    rob_clear = 1;
    drive_alu(12, 32'h555, 1, 32'h80);
    cycle();
    check("flush_valid", cdb_valid, 0);
    check("flush_alu_full", alu_full, 0);
    check("flush_lsb_full", lsb_full, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_quiet", cdb_valid, 0);
    end

    // Stall with id 5 on the bus and an LSB result waiting behind it.
    if (m_rr) begin
      drive_alu(1, 32'h1, 0, 0);
      drive_lsb(1, 32'h2);
      cycle();
      idle();
      repeat (2) cycle();
    end
    drive_alu(5, 32'h55, 0, 0);
    drive_lsb(6, 32'h66);
    cycle();
    check("stall_pre_id", cdb_rob_id, 5);
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0;
      randomize_inputs();
      rob_clear = 1'($urandom_range(0, 1));
      cycle();
      check("stall_valid", cdb_valid, 1);
      check("stall_id", cdb_rob_id, 5);
    end
    idle();
    cycle();
    check("stall_resume_id", cdb_rob_id, 6);
    check("stall_resume_src", cdb_src, 1);
    cycle();

    // Random traffic; producers mostly honour the full flags.
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      if (alu_full && $urandom_range(0, 9) != 0) alu_valid = 0;
      if (lsb_full && $urandom_range(0, 9) != 0) lsb_valid = 0;
      rdy_in    = ($urandom_range(0, 9) != 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle();
    rob_clear = 1;
    cycle();
    idle();

    // Ignoring full on both sides must overflow and set the sticky flag.
    for (int i = 0; i < 14; i++) begin
      drive_alu(i, 32'h600 + i, 0, 0);
      drive_lsb(i, 32'h700 + i);
      cycle();
    end
    check("ovf_set", ovf, 1);
    idle();
    cycle();
    check("ovf_sticky", ovf, 1);

    // Asynchronous reset in mid-traffic, then a JALR result afterwards.
    drive_alu(7, 32'h77, 1, 32'h700);
    drive_lsb(9, 32'h99);
    cycle();
    idle();
    #3;
    rst_in = 0;
    #1;
    model_reset();
    check("rst_valid", cdb_valid, 0);
    check("rst_id", cdb_rob_id, 0);
    check("rst_value", cdb_value, 0);
    check("rst_npc", cdb_new_pc, 0);
    check("rst_ovf", ovf, 0);
    check_all();
    @(negedge clk_in);
    rst_in = 1;
    drive_alu(0, 32'h1, 1, 32'h100);
    cycle();
    check("post_rst_valid", cdb_valid, 1);
    check("post_rst_npc", cdb_new_pc, 32'h100);
    check("post_rst_hnp", cdb_has_new_pc, 1);
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the reservation-station ALU and the load/store buffer.
- Buffers losing results in per-source FIFOs and grants the bus round-robin on contention.
- Drives one registered broadcast to the ROB, RS and LSB operand-wakeup logic, so consumers compare tags against exactly one result per cycle.
- Sits between the execution units and the ROB; flushed by rob_clear.

Parameters:
- ROB_W, 4, ROB index width; must match the `ROB_R` range width.
- DEPTH, 4, entries per source FIFO; power of two, ≥2.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low = freeze all state.
- rob_clear  in  1  mispredict flush.
- alu_valid  in  1  ALU result present this cycle.
- alu_rob_id  in  ROB_W  destination ROB tag of the ALU result.
- alu_value  in  32  ALU result.
- alu_has_new_pc  in  1  JALR target accompanies the ALU result.
- alu_new_pc  in  32  JALR target.
- lsb_valid  in  1  LSB result present this cycle.
- lsb_rob_id  in  ROB_W  destination ROB tag of the LSB result.
- lsb_value  in  32  load data.
- alu_full  out  1  ALU producer must not issue next cycle.
- lsb_full  out  1  LSB producer must not issue next cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_W  broadcast tag.
- cdb_value  out  32  broadcast value.
- cdb_src  out  1  source of the broadcast: 0 = ALU, 1 = LSB.
- cdb_has_new_pc  out  1  JALR target valid (ALU source only).
- cdb_new_pc  out  32  JALR target.
- ovf  out  1  sticky overflow flag; a result was dropped.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - both FIFOs empty;
  - cdb_valid=0, cdb_has_new_pc=0, cdb_src=0;
  - cdb_rob_id=0, cdb_value=0, cdb_new_pc=0;
  - rr pointer=0 (ALU favoured), ovf=0.
- rdy_in=0: every register holds, inputs are ignored, outputs are unchanged. cdb_valid therefore holds; consumers are also stalled.
- rob_clear=1 (with rdy_in=1), at the next edge:
  - both FIFOs emptied and that cycle's inputs dropped;
  - cdb_valid=0, cdb_has_new_pc=0;
  - rr pointer and ovf unchanged.
- Effective head per source = FIFO head if the FIFO is non-empty, else the same-cycle input if valid.
- Arbitration, each cycle with rdy_in=1 and rob_clear=0:
  - One head valid: that head wins.
  - Both heads valid: the source named by rr wins; rr then toggles to the other source.
  - rr changes only on a contended grant.
  - Winner is registered into the cdb_* outputs at the edge, so cdb_valid is high for exactly one cycle per result.
  - No head valid: cdb_valid=0 next cycle; the other cdb_* fields hold.
- Latency: an input arriving with its FIFO empty and winning appears on the CDB at the next edge (1 cycle). Every FIFO-resident result adds 1 cycle per queued predecessor, plus any lost arbitrations.
- FIFO update per source, in the same cycle:
  - pop if the FIFO head won;
  - push the input if valid and it was not bypassed directly to the output;
  - simultaneous push and pop keeps the count.
  - Ordering within a source is strictly FIFO.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
- Backpressure: x_full = (count_x ≥ DEPTH-1), combinational from registered count. One issue already in flight is always absorbed.
- Overflow: a push into a FIFO holding DEPTH entries with no same-cycle pop is dropped, and ovf is set to 1 (sticky until reset).
- cdb_has_new_pc / cdb_new_pc are forced to 0 when cdb_src=1.
- Reset asserted mid-operation overrides all other activity immediately.

Decomposition:
- Shared package (const.v):
  - `ROB_R` range and ROB width;
  - CDB source encodings SRC_ALU=0, SRC_LSB=1;
  - CDB_FIFO_DEPTH default.
- One sub-module, cdb_fifo: parameterised by data width and DEPTH.
  - Ports: push, pop, flush, din, dout, count, empty.
  - Async active-low reset.
  - Instantiated twice, with payload widths ROB_W+65 (ALU) and ROB_W+32 (LSB).

Test Plan:
- ALU only: alu_valid, rob_id=3, value=0x11 at cycle 0 → cycle 1: cdb_valid=1, rob_id=3, value=0x11, src=0; cycle 2: cdb_valid=0.
- Contention: cycle 0 ALU (id 1, 0xA) and LSB (id 2, 0xB) together, rr=0 → cycle 1 ALU id 1; cycle 2 LSB id 2. Repeating the same stimulus at cycle 3 → LSB first at cycle 4, then ALU at cycle 5.
- Backpressure: LSB valid every cycle with ids 4,5,6,7 while ALU is valid every cycle with ids 8..11 → lsb_full=1 once its count reaches 3; all eight tags broadcast exactly once; per-source order preserved; ovf stays 0.
- Flush: 2 entries queued per FIFO, rob_clear pulsed at cycle k with a new ALU input → cycle k+1: cdb_valid=0; no further broadcasts; both full flags 0.
- Stall: rdy_in=0 for 3 cycles with cdb_valid=1 (id 5) and inputs toggling → outputs frozen at id 5; inputs ignored; resumes with the identical queue on rdy_in=1.
- Reset: rst_in driven low between clock edges while traffic is queued → all outputs 0 immediately (asynchronously); after release, the first ALU input (id 0, 0x1, has_new_pc=1, new_pc=0x100) is broadcast 1 cycle later with cdb_new_pc=0x100.
